// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_pkg (package)
// Purpose : Shared definitions for the MEM/WB pipeline stage.
//           - Default data / register-index widths
//           - Zero constants for payload fields
//           - Packed MEM/WB payload width and a helper to compute it
//           - Occupancy encodings
//           - Skid-buffer state encoding: {main_v, skid_v}
// Revision: 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PIPE_XLEN   = 32;
    localparam int PIPE_REG_AW = 5;

    localparam logic [PIPE_XLEN-1:0]   XLEN_ZERO = '0;
    localparam logic [PIPE_REG_AW-1:0] REG_ZERO  = '0;

    // alu_result + load_data + rd + wb_reg_file + memtoreg
    localparam int MEMWB_PAYLOAD_W = 2*PIPE_XLEN + PIPE_REG_AW + 2;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // Bit 1 is the main-entry valid, bit 0 the skid-entry valid, so the
    // handshake outputs can be taken straight from the state register.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'b00,
        SKID_ONE   = 2'b10,
        SKID_FULL  = 2'b11
    } skid_state_e;

    function automatic int memwb_payload_w(input int xlen, input int reg_aw);
        return 2*xlen + reg_aw + 2;
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_buf
// Purpose : Generic valid/ready payload buffer with synchronous flush.
//           SKID != 0 : 2-entry skid buffer, registered in_ready (~skid_v).
//           SKID == 0 : single entry, in_ready = ~out_valid | out_ready.
// Ports   : clk, rst (async, active-high), flush
//           in_valid / in_ready / in_data[W]      upstream handshake
//           out_valid / out_ready / out_data[W]   downstream handshake (head)
//           occupancy[2]                          entries currently held
// Revision: 1.0 - initial release
// ============================================================================
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int W    = MEMWB_PAYLOAD_W,
    parameter int SKID = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   occupancy
);

    logic w_push;
    logic w_pop;

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    if (SKID != 0) begin : g_skid
        skid_state_e  r_state;
        logic [W-1:0] r_main;
        logic [W-1:0] r_skid;

        // Flush wins over accept/pop; the payload registers are left stale
        // since nothing downstream looks at them while out_valid is low.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= SKID_EMPTY;
                r_main  <= '0;
                r_skid  <= '0;
            end else if (flush) begin
                r_state <= SKID_EMPTY;
            end else begin
                case (r_state)
                    SKID_EMPTY: begin
                        if (w_push) begin
                            r_main  <= in_data;
                            r_state <= SKID_ONE;
                        end
                    end
                    SKID_ONE: begin
                        if (w_push && w_pop) begin
                            r_main <= in_data;
                        end else if (w_push) begin
                            r_skid  <= in_data;
                            r_state <= SKID_FULL;
                        end else if (w_pop) begin
                            r_state <= SKID_EMPTY;
                        end
                    end
                    SKID_FULL: begin
                        // in_ready is low here, so only a pop can happen.
                        if (w_pop) begin
                            r_main  <= r_skid;
                            r_state <= SKID_ONE;
                        end
                    end
                    default: r_state <= SKID_EMPTY;
                endcase
            end
        end

        assign out_valid = r_state[1];
        assign in_ready  = ~r_state[0];
        assign out_data  = r_main;
        assign occupancy = (r_state == SKID_FULL) ? OCC_FULL :
                           (r_state == SKID_ONE)  ? OCC_ONE  : OCC_EMPTY;
    end else begin : g_single
        logic         r_valid;
        logic [W-1:0] r_data;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (flush) begin
                r_valid <= 1'b0;
            end else if (w_push) begin
                // Covers both the empty load and the same-cycle pop/reload.
                r_valid <= 1'b1;
                r_data  <= in_data;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end

        assign out_valid = r_valid;
        assign in_ready  = ~r_valid | out_ready;
        assign out_data  = r_data;
        assign occupancy = r_valid ? OCC_ONE : OCC_EMPTY;
    end

endmodule : pipe_skid_buf
`default_nettype wire

// File: rtl/mem_wb_pipe_skid.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_pipe_skid
// Purpose : MEM/WB pipeline stage with valid/ready handshake, flush and an
//           optional 2-entry skid buffer. Exposes the selected writeback
//           value and a valid-qualified register-file write enable.
// Ports   : clk, rst (async, active-high), flush
//           in_valid/in_ready, alu_result_in, load_data_in, rd_in,
//           wb_reg_file_in, memtoreg_in                    from MEM
//           out_valid/out_ready, alu_result_out, load_data_out, rd_out,
//           wb_reg_file_out, memtoreg_out                  head entry to WB
//           wb_data_out, wb_we_out                         writeback / forwarding
//           occupancy                                      entries held (0..2)
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb_pipe_skid
    import pipe_pkg::*;
#(
    parameter int XLEN   = PIPE_XLEN,
    parameter int REG_AW = PIPE_REG_AW,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   load_data_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              wb_reg_file_in,
    input  logic              memtoreg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_result_out,
    output logic [XLEN-1:0]   load_data_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              wb_reg_file_out,
    output logic              memtoreg_out,
    output logic [XLEN-1:0]   wb_data_out,
    output logic              wb_we_out,
    output logic [1:0]        occupancy
);

    localparam int c_PAYLOAD_W = memwb_payload_w(XLEN, REG_AW);

    logic [c_PAYLOAD_W-1:0] w_in_payload;
    logic [c_PAYLOAD_W-1:0] w_out_payload;

    assign w_in_payload = {alu_result_in, load_data_in, rd_in,
                           wb_reg_file_in, memtoreg_in};

    pipe_skid_buf #(
        .W    (c_PAYLOAD_W),
        .SKID (SKID)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload),
        .occupancy (occupancy)
    );

    assign {alu_result_out, load_data_out, rd_out,
            wb_reg_file_out, memtoreg_out} = w_out_payload;

    assign wb_data_out = memtoreg_out ? load_data_out : alu_result_out;

    // x0 is hard-wired to zero, so writes to it are never reported.
    assign wb_we_out = out_valid & wb_reg_file_out & (rd_out != '0);

endmodule : mem_wb_pipe_skid
`default_nettype wire

// File: tb/tb_mem_wb_pipe_skid.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_wb_pipe_skid
// Purpose : Self-checking bench for mem_wb_pipe_skid. Instance A uses the
//           2-entry skid buffer, instance B the single-entry variant.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_wb_pipe_skid;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        we;
        logic        m2r;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A (SKID=1)
    logic        flush_a, iv_a, ir_a, ov_a, or_a;
    ent_t        in_a;
    logic [31:0] alu_a, ld_a, wbd_a;
    logic [4:0]  rd_a;
    logic        we_a, m2r_a, wbwe_a;
    logic [1:0]  occ_a;

    // Instance B (SKID=0)
    logic        flush_b, iv_b, ir_b, ov_b, or_b;
    ent_t        in_b;
    logic [31:0] alu_b, ld_b, wbd_b;
    logic [4:0]  rd_b;
    logic        we_b, m2r_b, wbwe_b;
    logic [1:0]  occ_b;

    int n_checks = 0;
    int n_fail   = 0;

    mem_wb_pipe_skid #(.XLEN(32), .REG_AW(5), .SKID(1)) u_dut_a (
        .clk(clk), .rst(rst), .flush(flush_a),
        .in_valid(iv_a), .in_ready(ir_a),
        .alu_result_in(in_a.alu), .load_data_in(in_a.ld), .rd_in(in_a.rd),
        .wb_reg_file_in(in_a.we), .memtoreg_in(in_a.m2r),
        .out_valid(ov_a), .out_ready(or_a),
        .alu_result_out(alu_a), .load_data_out(ld_a), .rd_out(rd_a),
        .wb_reg_file_out(we_a), .memtoreg_out(m2r_a),
        .wb_data_out(wbd_a), .wb_we_out(wbwe_a), .occupancy(occ_a)
    );

    mem_wb_pipe_skid #(.XLEN(32), .REG_AW(5), .SKID(0)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush_b),
        .in_valid(iv_b), .in_ready(ir_b),
        .alu_result_in(in_b.alu), .load_data_in(in_b.ld), .rd_in(in_b.rd),
        .wb_reg_file_in(in_b.we), .memtoreg_in(in_b.m2r),
        .out_valid(ov_b), .out_ready(or_b),
        .alu_result_out(alu_b), .load_data_out(ld_b), .rd_out(rd_b),
        .wb_reg_file_out(we_b), .memtoreg_out(m2r_b),
        .wb_data_out(wbd_b), .wb_we_out(wbwe_b), .occupancy(occ_b)
    );

    task automatic idle_inputs();
        flush_a = 1'b0; iv_a = 1'b0; or_a = 1'b0; in_a = '0;
        flush_b = 1'b0; iv_b = 1'b0; or_b = 1'b0; in_b = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, occ_a, wbwe_a, wbd_a, alu_a, ld_a, rd_a, we_a, m2r_a, ir_a} !==
            {1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_a: got v=%b occ=%0d we=%b wbd=%h alu=%h ir=%b, want all zero with ir=1",
                     ov_a, occ_a, wbwe_a, wbd_a, alu_a, ir_a);
        end
        n_checks++;
        if ({ov_b, occ_b, wbwe_b, wbd_b, alu_b, ld_b, rd_b, we_b, m2r_b, ir_b} !==
            {1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_b: got v=%b occ=%0d we=%b wbd=%h alu=%h ir=%b, want all zero with ir=1",
                     ov_b, occ_b, wbwe_b, wbd_b, alu_b, ir_b);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, occ_a, ir_a} !== {1'b0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release: got v=%b occ=%0d ir=%b, want 0 0 1", ov_a, occ_a, ir_a);
        end
    endtask

    task automatic test_basic();
        @(negedge clk);
        in_a = '{alu: 32'h11, ld: 32'h0, rd: 5'd3, we: 1'b1, m2r: 1'b0};
        iv_a = 1'b1;
        or_a = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, wbd_a, wbwe_a, rd_a, occ_a} !== {1'b1, 32'h11, 1'b1, 5'd3, 2'd1}) begin
            n_fail++;
            $display("FAIL basic: got v=%b wbd=%h we=%b rd=%0d occ=%0d, want 1 11 1 3 1",
                     ov_a, wbd_a, wbwe_a, rd_a, occ_a);
        end
        @(negedge clk);
        iv_a = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, wbwe_a, occ_a} !== {1'b0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL basic_drain: got v=%b we=%b occ=%0d, want 0 0 0", ov_a, wbwe_a, occ_a);
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        or_a = 1'b0;
        iv_a = 1'b1;
        in_a = '{alu: 32'h1, ld: 32'h100, rd: 5'd1, we: 1'b1, m2r: 1'b0};
        @(posedge clk);
        #1;
        n_checks++;
        if ({occ_a, ir_a, alu_a} !== {2'd1, 1'b1, 32'h1}) begin
            n_fail++;
            $display("FAIL bp_one: got occ=%0d ir=%b alu=%h, want 1 1 1", occ_a, ir_a, alu_a);
        end
        @(negedge clk);
        in_a = '{alu: 32'h2, ld: 32'h200, rd: 5'd2, we: 1'b1, m2r: 1'b0};
        @(posedge clk);
        #1;
        n_checks++;
        if ({occ_a, ir_a, alu_a} !== {2'd2, 1'b0, 32'h1}) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d ir=%b alu=%h, want 2 0 1", occ_a, ir_a, alu_a);
        end
        // Presenting while not ready must change nothing.
        @(negedge clk);
        in_a = '{alu: 32'h3, ld: 32'h300, rd: 5'd4, we: 1'b1, m2r: 1'b0};
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, occ_a, alu_a, ld_a, rd_a} !== {1'b1, 2'd2, 32'h1, 32'h100, 5'd1}) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%b occ=%0d alu=%h ld=%h rd=%0d, want 1 2 1 100 1",
                     ov_a, occ_a, alu_a, ld_a, rd_a);
        end
        @(negedge clk);
        iv_a = 1'b0;
        or_a = 1'b1;
        #1;
        n_checks++;
        if (ir_a !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pop_cycle_ready: got ir=%b, want 0", ir_a);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, alu_a, occ_a, ir_a} !== {1'b1, 32'h2, 2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL bp_second: got v=%b alu=%h occ=%0d ir=%b, want 1 2 1 1",
                     ov_a, alu_a, occ_a, ir_a);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, occ_a} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%b occ=%0d, want 0 0", ov_a, occ_a);
        end
    endtask

    task automatic test_memtoreg();
        @(negedge clk);
        in_a = '{alu: 32'hBEEF, ld: 32'hDEAD, rd: 5'd0, we: 1'b1, m2r: 1'b1};
        iv_a = 1'b1;
        or_a = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_a, wbd_a, wbwe_a, we_a, m2r_a} !== {1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL memtoreg_rd0: got v=%b wbd=%h we=%b wrf=%b m2r=%b, want 1 dead 0 1 1",
                     ov_a, wbd_a, wbwe_a, we_a, m2r_a);
        end
        @(negedge clk);
        in_a = '{alu: 32'hBEEF, ld: 32'hDEAD, rd: 5'd9, we: 1'b1, m2r: 1'b1};
        @(posedge clk);
        #1;
        n_checks++;
        if ({wbd_a, wbwe_a} !== {32'hDEAD, 1'b1}) begin
            n_fail++;
            $display("FAIL memtoreg_rd9: got wbd=%h we=%b, want dead 1", wbd_a, wbwe_a);
        end
        @(negedge clk);
        iv_a = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_flush();
        @(negedge clk);
        or_a = 1'b0;
        iv_a = 1'b1;
        in_a = '{alu: 32'hA1, ld: 32'h0, rd: 5'd1, we: 1'b1, m2r: 1'b0};
        @(posedge clk);
        @(negedge clk);
        in_a.alu = 32'hA2;
        @(posedge clk);
        #1;
        n_checks++;
        if (occ_a !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_prefill: got occ=%0d, want 2", occ_a);
        end
        @(negedge clk);
        flush_a = 1'b1;
        in_a.alu = 32'hFF;
        @(posedge clk);
        #1;
        n_checks++;
        if ({occ_a, ov_a, ir_a, wbwe_a} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_full: got occ=%0d v=%b ir=%b we=%b, want 0 0 1 0",
                     occ_a, ov_a, ir_a, wbwe_a);
        end
        @(negedge clk);
        flush_a = 1'b0;
        in_a.alu = 32'hB1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({occ_a, alu_a} !== {2'd1, 32'hB1}) begin
            n_fail++;
            $display("FAIL flush_refill: got occ=%0d alu=%h, want 1 b1", occ_a, alu_a);
        end
        // Input offered with in_ready high during flush must still be dropped.
        @(negedge clk);
        flush_a = 1'b1;
        in_a.alu = 32'hB2;
        #1;
        n_checks++;
        if (ir_a !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_ready: got ir=%b, want 1", ir_a);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({occ_a, ov_a} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_one: got occ=%0d v=%b, want 0 0", occ_a, ov_a);
        end
        @(negedge clk);
        flush_a = 1'b0;
        iv_a = 1'b0;
        or_a = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({occ_a, ov_a} !== {2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_no_ghost: got occ=%0d v=%b alu=%h, want empty", occ_a, ov_a, alu_a);
        end
        // Single-entry variant.
        @(negedge clk);
        or_b = 1'b0;
        iv_b = 1'b1;
        in_b = '{alu: 32'hC1, ld: 32'h0, rd: 5'd2, we: 1'b1, m2r: 1'b0};
        @(posedge clk);
        @(negedge clk);
        flush_b = 1'b1;
        in_b.alu = 32'hC2;
        @(posedge clk);
        #1;
        n_checks++;
        if ({occ_b, ov_b, ir_b, wbwe_b} !== {2'd0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_b: got occ=%0d v=%b ir=%b we=%b, want 0 0 1 0",
                     occ_b, ov_b, ir_b, wbwe_b);
        end
        @(negedge clk);
        flush_b = 1'b0;
        iv_b = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        or_a = 1'b0;
        iv_a = 1'b1;
        in_a = '{alu: 32'h77, ld: 32'h55, rd: 5'd7, we: 1'b1, m2r: 1'b0};
        @(posedge clk);
        @(negedge clk);
        in_a.alu = 32'h78;
        @(posedge clk);
        #1;
        n_checks++;
        if (occ_a !== 2'd2) begin
            n_fail++;
            $display("FAIL rstmid_prefill: got occ=%0d, want 2", occ_a);
        end
        @(negedge clk);
        iv_a = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ov_a, occ_a, wbwe_a, wbd_a, alu_a, ld_a, rd_a, we_a, m2r_a, ir_a} !==
            {1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_async: got v=%b occ=%0d we=%b wbd=%h alu=%h ir=%b, want zeros ir=1",
                     ov_a, occ_a, wbwe_a, wbd_a, alu_a, ir_a);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_skid0();
        @(negedge clk);
        or_b = 1'b0;
        iv_b = 1'b1;
        in_b = '{alu: 32'h5, ld: 32'h0, rd: 5'd5, we: 1'b1, m2r: 1'b0};
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_b, occ_b, ir_b, alu_b} !== {1'b1, 2'd1, 1'b0, 32'h5}) begin
            n_fail++;
            $display("FAIL skid0_stall: got v=%b occ=%0d ir=%b alu=%h, want 1 1 0 5",
                     ov_b, occ_b, ir_b, alu_b);
        end
        @(negedge clk);
        or_b = 1'b1;
        in_b.alu = 32'h6;
        #1;
        n_checks++;
        if (ir_b !== 1'b1) begin
            n_fail++;
            $display("FAIL skid0_comb_ready: got ir=%b, want 1", ir_b);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_b, occ_b, alu_b} !== {1'b1, 2'd1, 32'h6}) begin
            n_fail++;
            $display("FAIL skid0_reload: got v=%b occ=%0d alu=%h, want 1 1 6", ov_b, occ_b, alu_b);
        end
        @(negedge clk);
        iv_b = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ov_b, occ_b} !== {1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL skid0_drain: got v=%b occ=%0d, want 0 0", ov_b, occ_b);
        end
    endtask

    // Reference: each instance is an ideal FIFO of capacity 2 (A) or 1 (B).
    task automatic test_random();
        ent_t qa[$];
        ent_t qb[$];
        ent_t exp;
        logic exp_ir_a, exp_ir_b;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            n_checks++;
            if ({ov_a, occ_a} !== {(qa.size() != 0), 2'(qa.size())}) begin
                n_fail++;
                $display("FAIL rand_a_state cyc %0d: got v=%b occ=%0d, want v=%b occ=%0d",
                         cyc, ov_a, occ_a, (qa.size() != 0), qa.size());
            end
            if (qa.size() != 0) begin
                exp = qa[0];
                n_checks++;
                if ({alu_a, ld_a, rd_a, we_a, m2r_a} !== exp ||
                    wbd_a !== (exp.m2r ? exp.ld : exp.alu) ||
                    wbwe_a !== (exp.we && exp.rd != 5'd0)) begin
                    n_fail++;
                    $display("FAIL rand_a_head cyc %0d: got alu=%h ld=%h rd=%0d wbd=%h we=%b, want alu=%h ld=%h rd=%0d",
                             cyc, alu_a, ld_a, rd_a, wbd_a, wbwe_a, exp.alu, exp.ld, exp.rd);
                end
            end else begin
                n_checks++;
                if (wbwe_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_a_we_empty cyc %0d: got we=%b, want 0", cyc, wbwe_a);
                end
            end
            n_checks++;
            if ({ov_b, occ_b} !== {(qb.size() != 0), 2'(qb.size())}) begin
                n_fail++;
                $display("FAIL rand_b_state cyc %0d: got v=%b occ=%0d, want v=%b occ=%0d",
                         cyc, ov_b, occ_b, (qb.size() != 0), qb.size());
            end
            if (qb.size() != 0) begin
                exp = qb[0];
                n_checks++;
                if ({alu_b, ld_b, rd_b, we_b, m2r_b} !== exp ||
                    wbd_b !== (exp.m2r ? exp.ld : exp.alu) ||
                    wbwe_b !== (exp.we && exp.rd != 5'd0)) begin
                    n_fail++;
                    $display("FAIL rand_b_head cyc %0d: got alu=%h ld=%h rd=%0d wbd=%h we=%b, want alu=%h ld=%h rd=%0d",
                             cyc, alu_b, ld_b, rd_b, wbd_b, wbwe_b, exp.alu, exp.ld, exp.rd);
                end
            end

            iv_a    = ($urandom_range(0, 99) < 60);
            or_a    = ($urandom_range(0, 99) < 55);
            flush_a = ($urandom_range(0, 63) == 0);
            in_a    = '{alu: $urandom, ld: $urandom, rd: 5'($urandom),
                        we: 1'($urandom), m2r: 1'($urandom)};
            iv_b    = ($urandom_range(0, 99) < 60);
            or_b    = ($urandom_range(0, 99) < 55);
            flush_b = ($urandom_range(0, 63) == 0);
            in_b    = '{alu: $urandom, ld: $urandom, rd: 5'($urandom),
                        we: 1'($urandom), m2r: 1'($urandom)};
            #1;
            exp_ir_a = (qa.size() < 2);
            exp_ir_b = (qb.size() == 0) || or_b;
            n_checks++;
            if ({ir_a, ir_b} !== {exp_ir_a, exp_ir_b}) begin
                n_fail++;
                $display("FAIL rand_ready cyc %0d: got ir_a=%b ir_b=%b, want %b %b",
                         cyc, ir_a, ir_b, exp_ir_a, exp_ir_b);
            end

            if (flush_a) begin
                qa.delete();
            end else begin
                if (qa.size() != 0 && or_a) void'(qa.pop_front());
                if (iv_a && exp_ir_a) qa.push_back(in_a);
            end
            if (flush_b) begin
                qb.delete();
            end else begin
                if (qb.size() != 0 && or_b) void'(qb.pop_front());
                if (iv_b && exp_ir_b) qb.push_back(in_b);
            end
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_memtoreg();
        test_flush();
        test_reset_mid();
        test_skid0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mem_wb_pipe_skid
`default_nettype wire
